// File: rtl/riscv_tlm_counters.sv
// Telemetry counters (mcycle/minstret/stall) with a tear-free 64-bit register window.
// Optional overflow interrupt enabled by defining TLM_OVF_IRQ_EN.
module riscv_tlm_counters #(
    parameter int CNT_W  = 64,
    parameter int ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              retire_i,
    input  logic              stall_i,
    input  logic              req_valid_i,
    input  logic              req_wr_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              req_ready_o,
    output logic              rsp_valid_o,
    output logic [31:0]       rsp_rdata_o,
    output logic [CNT_W-1:0]  tlm_mcycle_o,
    output logic [CNT_W-1:0]  tlm_minstret_o,
    output logic [CNT_W-1:0]  tlm_stall_o,
    output logic              irq_o
);
    localparam int HW = CNT_W - 32;

    // index 0 = mcycle, 1 = minstret, 2 = stall
    logic [2:0][CNT_W-1:0] r_cnt;
    logic [2:0][HW-1:0]    r_sh;
    logic                  r_freeze;
    logic [2:0]            r_ovf;
    logic                  r_rsp_valid;
    logic [31:0]           r_rdata;

    logic [ADDR_W-1:0] w_word;
    logic [2:0]        w_idx;
    logic              w_mapped;
    logic              w_acc;
    logic              w_wr;
    logic              w_rd;
    logic              w_clr;
    logic              w_st_wr;
    logic [2:0]        w_inc;
    logic [2:0]        w_ld;
    logic [2:0]        w_cap;
    logic [2:0]        w_wrap;
    logic [2:0]        w_ien;
    logic [31:0]       w_rdata;

    assign w_word   = req_addr_i >> 2;
    assign w_idx    = w_word[2:0];
    assign w_mapped = (w_word[ADDR_W-1:3] == '0);
    assign w_acc    = req_valid_i && !r_rsp_valid;
    assign w_wr     = w_acc && req_wr_i && w_mapped;
    assign w_rd     = w_acc && !req_wr_i && w_mapped;
    assign w_clr    = w_wr && (w_idx == 3'd6) && req_wdata_i[1];
    assign w_st_wr  = w_wr && (w_idx == 3'd7);
    assign w_inc    = {stall_i, retire_i, 1'b1};

    always_comb begin
        w_ld   = '0;
        w_cap  = '0;
        w_wrap = '0;
        for (int k = 0; k < 3; k++) begin
            w_ld[k]   = w_wr && r_freeze && (w_idx[2:1] == 2'(k));
            w_cap[k]  = w_rd && (w_idx == {2'(k), 1'b0});
            w_wrap[k] = !w_clr && !r_freeze && w_inc[k] && (&r_cnt[k]);
        end
    end

    always_comb begin
        w_rdata = '0;
        if (w_rd) begin
            case (w_idx)
                3'd0: w_rdata = r_cnt[0][31:0];
                3'd1: w_rdata = 32'(r_sh[0]);
                3'd2: w_rdata = r_cnt[1][31:0];
                3'd3: w_rdata = 32'(r_sh[1]);
                3'd4: w_rdata = r_cnt[2][31:0];
                3'd5: w_rdata = 32'(r_sh[2]);
                3'd6: w_rdata = {31'd0, r_freeze};
                default: w_rdata = {21'd0, w_ien, 5'd0, r_ovf};
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt       <= '0;
            r_sh        <= '0;
            r_freeze    <= 1'b0;
            r_ovf       <= '0;
            r_rsp_valid <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_rsp_valid <= w_acc;
            r_rdata     <= w_rdata;
            if (w_wr && (w_idx == 3'd6))
                r_freeze <= req_wdata_i[0];
            // a wrap in the same cycle as a W1C keeps the sticky bit set
            r_ovf <= (r_ovf & ~(w_st_wr ? req_wdata_i[2:0] : 3'b000)) | w_wrap;
            for (int k = 0; k < 3; k++) begin
                if (w_clr) begin
                    r_cnt[k] <= '0;
                    r_sh[k]  <= '0;
                end else begin
                    if (w_ld[k]) begin
                        if (w_idx[0])
                            r_cnt[k][CNT_W-1:32] <= req_wdata_i[HW-1:0];
                        else
                            r_cnt[k][31:0] <= req_wdata_i;
                    end else if (!r_freeze && w_inc[k]) begin
                        r_cnt[k] <= r_cnt[k] + 1'b1;
                    end
                    if (w_cap[k])
                        r_sh[k] <= r_cnt[k][CNT_W-1:32];
                end
            end
        end
    end

`ifdef TLM_OVF_IRQ_EN
    logic [2:0] r_ien;
    logic       r_irq;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ien <= '0;
            r_irq <= 1'b0;
        end else begin
            if (w_st_wr)
                r_ien <= req_wdata_i[10:8];
            r_irq <= |(r_ovf & r_ien);
        end
    end

    assign w_ien = r_ien;
    assign irq_o = r_irq;
`else
    assign w_ien = 3'b000;
    assign irq_o = 1'b0;
`endif

    assign req_ready_o    = !r_rsp_valid;
    assign rsp_valid_o    = r_rsp_valid;
    assign rsp_rdata_o    = r_rdata;
    assign tlm_mcycle_o   = r_cnt[0];
    assign tlm_minstret_o = r_cnt[1];
    assign tlm_stall_o    = r_cnt[2];

endmodule

// File: tb/tb_riscv_tlm_counters.sv
// Bench for riscv_tlm_counters: directed sequences, a register table and random traffic
// checked against a counting model; honours TLM_OVF_IRQ_EN.
module tb_riscv_tlm_counters;
`ifdef TLM_OVF_IRQ_EN
    localparam bit IRQ = 1'b1;
`else
    localparam bit IRQ = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        retire_i, stall_i;
    logic        req_valid_i, req_wr_i;
    logic [4:0]  req_addr_i;
    logic [31:0] req_wdata_i;
    logic        req_ready_o, rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic [63:0] tlm_mcycle_o, tlm_minstret_o, tlm_stall_o;
    logic        irq_o;

    riscv_tlm_counters dut (
        .clk_i(clk_i), .rst_i(rst_i), .retire_i(retire_i), .stall_i(stall_i),
        .req_valid_i(req_valid_i), .req_wr_i(req_wr_i), .req_addr_i(req_addr_i),
        .req_wdata_i(req_wdata_i), .req_ready_o(req_ready_o), .rsp_valid_o(rsp_valid_o),
        .rsp_rdata_o(rsp_rdata_o), .tlm_mcycle_o(tlm_mcycle_o),
        .tlm_minstret_o(tlm_minstret_o), .tlm_stall_o(tlm_stall_o), .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: plain counts, shadows hold HI words
    longint unsigned m_cnt [3];
    bit [31:0]       m_sh  [3];
    bit              m_frz, m_irq, m_rspv;
    bit [2:0]        m_ovf, m_ien;
    bit [31:0]       m_rdata;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_cnt[k] = 0;
            m_sh[k]  = 0;
        end
        m_frz = 0; m_irq = 0; m_rspv = 0; m_ovf = 0; m_ien = 0; m_rdata = 0;
    endtask

    function automatic bit [31:0] status_val();
        return (IRQ ? (32'(m_ien) << 8) : 32'd0) | 32'(m_ovf);
    endfunction

    task automatic model_edge();
        bit        acc, wr, rd, clr;
        int        a;
        bit [2:0]  inc, wraps, w1c;
        bit [31:0] rdv;
        acc = req_valid_i && !m_rspv;
        wr  = acc && req_wr_i;
        rd  = acc && !req_wr_i;
        a   = int'(req_addr_i) / 4;
        inc = {stall_i, retire_i, 1'b1};
        rdv = 0;
        if (rd) begin
            if (a < 6) rdv = (a % 2 == 0) ? m_cnt[a/2][31:0] : m_sh[a/2];
            else if (a == 6) rdv = 32'(m_frz);
            else rdv = status_val();
        end
        m_irq = IRQ && ((m_ovf & m_ien) != 0);
        clr   = wr && a == 6 && req_wdata_i[1];
        wraps = 0;
        w1c   = (wr && a == 7) ? req_wdata_i[2:0] : 3'b000;
        for (int k = 0; k < 3; k++) begin
            if (clr) begin
                m_cnt[k] = 0;
                m_sh[k]  = 0;
            end else begin
                if (rd && a == 2 * k) m_sh[k] = m_cnt[k][63:32];
                if (m_frz) begin
                    if (wr && a / 2 == k && a < 6) begin
                        if (a % 2) m_cnt[k] = {req_wdata_i, m_cnt[k][31:0]};
                        else       m_cnt[k] = {m_cnt[k][63:32], req_wdata_i};
                    end
                end else if (inc[k]) begin
                    if (m_cnt[k] == 64'hFFFF_FFFF_FFFF_FFFF) wraps[k] = 1;
                    m_cnt[k] = m_cnt[k] + 1;
                end
            end
        end
        m_ovf = (m_ovf & ~w1c) | wraps;
        if (wr && a == 7) m_ien = req_wdata_i[10:8];
        if (wr && a == 6) m_frz = req_wdata_i[0];
        m_rspv  = acc;
        m_rdata = rdv;
    endtask

    task automatic step();
        @(posedge clk_i);
        model_edge();
        #1;
        chk("mcycle", tlm_mcycle_o, m_cnt[0]);
        chk("minstret", tlm_minstret_o, m_cnt[1]);
        chk("stall", tlm_stall_o, m_cnt[2]);
        chk("rsp_valid", rsp_valid_o, m_rspv);
        chk("req_ready", req_ready_o, !m_rspv);
        if (m_rspv) chk("rsp_rdata", rsp_rdata_o, m_rdata);
        chk("irq", irq_o, m_irq);
    endtask

    task automatic bus(input bit wr, input logic [4:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rd);
        req_valid_i = 1; req_wr_i = wr; req_addr_i = addr; req_wdata_i = wdata;
        step();
        rd = rsp_rdata_o;
        req_valid_i = 0;
        step();
    endtask

    typedef struct {
        bit          wr;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t        tv [14];
    logic [31:0] rd;

    initial begin
        tv[0]  = '{1, 5'h18, 32'h1,        32'h0};
        tv[1]  = '{1, 5'h00, 32'h11111111, 32'h0};
        tv[2]  = '{1, 5'h04, 32'h22222222, 32'h0};
        tv[3]  = '{1, 5'h10, 32'h33333333, 32'h0};
        tv[4]  = '{1, 5'h14, 32'h44444444, 32'h0};
        tv[5]  = '{0, 5'h04, 32'h0,        32'h0};
        tv[6]  = '{0, 5'h00, 32'h0,        32'h11111111};
        tv[7]  = '{0, 5'h04, 32'h0,        32'h22222222};
        tv[8]  = '{0, 5'h10, 32'h0,        32'h33333333};
        tv[9]  = '{0, 5'h14, 32'h0,        32'h44444444};
        tv[10] = '{0, 5'h18, 32'h0,        32'h1};
        tv[11] = '{0, 5'h08, 32'h0,        32'd30};
        tv[12] = '{0, 5'h0C, 32'h0,        32'h0};
        tv[13] = '{1, 5'h18, 32'h0,        32'h0};

        rst_i = 1; retire_i = 0; stall_i = 0;
        req_valid_i = 0; req_wr_i = 0; req_addr_i = 0; req_wdata_i = 0;
        model_reset();
        repeat (10) @(posedge clk_i);
        #1;
        chk("rst_mcycle", tlm_mcycle_o, 0);
        chk("rst_minstret", tlm_minstret_o, 0);
        chk("rst_stall", tlm_stall_o, 0);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_ready", req_ready_o, 1);
        chk("rst_irq", irq_o, 0);
        rst_i = 0;

        repeat (100) step();
        chk("idle_mcycle", tlm_mcycle_o, 100);
        chk("idle_minstret", tlm_minstret_o, 0);
        chk("idle_stall", tlm_stall_o, 0);

        for (int i = 0; i < 60; i++) begin
            retire_i = (i % 2 == 0);
            stall_i  = (i % 2 != 0);
            step();
        end
        retire_i = 0; stall_i = 0;
        chk("alt_minstret", tlm_minstret_o, 30);
        chk("alt_stall", tlm_stall_o, 30);
        chk("alt_mcycle", tlm_mcycle_o, 160);

        for (int i = 0; i < 14; i++) begin
            bus(tv[i].wr, tv[i].addr, tv[i].wdata, rd);
            chk($sformatf("table[%0d]", i), rd, tv[i].exp);
        end

        // LO read on the last cycle before the carry into HI
        bus(1, 5'h18, 32'h1, rd);
        bus(1, 5'h00, 32'hFFFFFFFE, rd);
        bus(1, 5'h04, 32'h0, rd);
        bus(1, 5'h18, 32'h0, rd);
        bus(0, 5'h00, 0, rd);
        chk("tear_lo", rd, 32'hFFFFFFFF);
        bus(0, 5'h04, 0, rd);
        chk("tear_hi_shadow", rd, 32'h0);
        chk("tear_live_hi", tlm_mcycle_o[63:32], 32'h1);

        bus(1, 5'h18, 32'h1, rd);
        bus(1, 5'h08, 32'hFFFFFFFF, rd);
        bus(1, 5'h0C, 32'hFFFFFFFF, rd);
        bus(1, 5'h18, 32'h0, rd);
        retire_i = 1;
        step();
        retire_i = 0;
        chk("wrap_minstret", tlm_minstret_o, 0);
        bus(0, 5'h1C, 0, rd);
        chk("wrap_status", rd, 32'h2);
        bus(1, 5'h1C, 32'h2, rd);
        bus(0, 5'h1C, 0, rd);
        chk("status_w1c", rd, 32'h0);

        // clear beats simultaneous increments
        retire_i = 1; stall_i = 1;
        req_valid_i = 1; req_wr_i = 1; req_addr_i = 5'h18; req_wdata_i = 32'h2;
        step();
        req_valid_i = 0;
        chk("clr_mcycle", tlm_mcycle_o, 0);
        chk("clr_minstret", tlm_minstret_o, 0);
        chk("clr_stall", tlm_stall_o, 0);
        step();
        chk("resume_mcycle", tlm_mcycle_o, 1);
        chk("resume_minstret", tlm_minstret_o, 1);
        chk("resume_stall", tlm_stall_o, 1);
        retire_i = 0; stall_i = 0;
        step();
        bus(0, 5'h18, 0, rd);
        chk("ctrl_clear_reads0", rd, 32'h0);

        bus(1, 5'h1C, 32'h100, rd);
        bus(1, 5'h18, 32'h1, rd);
        bus(1, 5'h00, 32'hFFFFFFFF, rd);
        bus(1, 5'h04, 32'hFFFFFFFF, rd);
        bus(1, 5'h18, 32'h0, rd);
        step();
        chk("irq_after_wrap", irq_o, IRQ);
        bus(0, 5'h1C, 0, rd);
        chk("irq_status", rd, IRQ ? 32'h101 : 32'h1);
        bus(1, 5'h1C, 32'h1, rd);
        step();
        chk("irq_cleared", irq_o, 0);

        for (int i = 0; i < 500; i++) begin
            retire_i = 1'($urandom_range(0, 1));
            stall_i  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3, 4, 5: bus(0, 5'($urandom_range(0, 7) * 4), 0, rd);
                    6: bus(1, 5'h18, {30'd0, ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1))}, rd);
                    7: bus(1, 5'h1C, $urandom, rd);
                    default: bus(1, 5'($urandom_range(0, 5) * 4),
                                 ($urandom_range(0, 1) != 0) ? 32'hFFFFFFFF : 32'($urandom), rd);
                endcase
            end else begin
                step();
            end
        end
        retire_i = 0; stall_i = 0;

        // reset lands while a read response is pending
        req_valid_i = 1; req_wr_i = 0; req_addr_i = 5'h00;
        step();
        req_valid_i = 0;
        rst_i = 1;
        #1;
        model_reset();
        chk("rstmid_rsp_valid", rsp_valid_o, 0);
        chk("rstmid_ready", req_ready_o, 1);
        chk("rstmid_mcycle", tlm_mcycle_o, 0);
        chk("rstmid_minstret", tlm_minstret_o, 0);
        chk("rstmid_stall", tlm_stall_o, 0);
        repeat (3) @(posedge clk_i);
        #1;
        chk("rstmid_no_ack", rsp_valid_o, 0);
        rst_i = 0;
        repeat (5) step();
        chk("post_rst_mcycle", tlm_mcycle_o, 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
